freq_div_ctrl_v1: RTL

//  Programmable clock-pulse divider controller. Generates a periodic pulse (high, then low for a
//  set number of cycles) from lclk, and lets a config master change period and low width

---
 rtl/freq_div_ctrl_v1.sv | 97 +++++++++
 1 files changed

// File: rtl/freq_div_ctrl_v1.sv
// Programmable pulse divider with strobe/ack reconfiguration applied only at period boundaries.
// Optional FDC_HALF_RATE_OUT_EN adds clock_half_fdc_negreg_out, a /2 toggle while running.
module freq_div_ctrl_v1 #(
  parameter int CNT_W   = 3,
  parameter int DEF_DIV = 7,
  parameter int DEF_LOW = 1
) (
  input  logic             lclk_fdc_in,
  input  logic             rst_fdc_in,
  input  logic             run_fdc_in,
  input  logic             cfg_req_fdc_in,
  input  logic [CNT_W-1:0] cfg_div_fdc_in,
  input  logic [CNT_W-1:0] cfg_low_fdc_in,
  output logic             cfg_ack_fdc_negreg_out,
  output logic             cfg_err_fdc_negreg_out,
  output logic             cfg_busy_fdc_negreg_out,
  output logic             clock_pulse_fdc_negreg_out,
`ifdef FDC_HALF_RATE_OUT_EN
  output logic             clock_half_fdc_negreg_out,
`endif
  output logic             period_end_fdc_negreg_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] act_low;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_low;
  logic             pend_vld;

  logic             cfg_ok;
  logic             accept;
  logic             at_end;
  logic             apply;
  logic [CNT_W-1:0] high_last;

  // A request is only taken when the pending slot is free; apply and accept are exclusive on pend_vld.
  always_comb begin
    cfg_ok    = (cfg_low_fdc_in != '0) && (cfg_low_fdc_in <= cfg_div_fdc_in);
    accept    = cfg_req_fdc_in && cfg_ok && !pend_vld;
    at_end    = (cnt == act_div);
    apply     = pend_vld && (!run_fdc_in || at_end);
    high_last = act_div - act_low;
  end

  always_ff @(negedge lclk_fdc_in) begin
    if (rst_fdc_in) begin
      cnt                        <= '0;
      act_div                    <= CNT_W'(DEF_DIV);
      act_low                    <= CNT_W'(DEF_LOW);
      pend_div                   <= '0;
      pend_low                   <= '0;
      pend_vld                   <= 1'b0;
      cfg_ack_fdc_negreg_out     <= 1'b0;
      cfg_err_fdc_negreg_out     <= 1'b0;
      clock_pulse_fdc_negreg_out <= 1'b0;
      period_end_fdc_negreg_out  <= 1'b0;
    end else begin
      cfg_ack_fdc_negreg_out     <= accept;
      cfg_err_fdc_negreg_out     <= cfg_req_fdc_in && !accept;
      // Pulse and strobe use the settings active before this edge, even on an apply edge.
      clock_pulse_fdc_negreg_out <= run_fdc_in && (cnt <= high_last);
      period_end_fdc_negreg_out  <= run_fdc_in && at_end;

      if (!run_fdc_in || at_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end

      if (apply) begin
        act_div  <= pend_div;
        act_low  <= pend_low;
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_div <= cfg_div_fdc_in;
        pend_low <= cfg_low_fdc_in;
        pend_vld <= 1'b1;
      end
    end
  end

  assign cfg_busy_fdc_negreg_out = pend_vld;

`ifdef FDC_HALF_RATE_OUT_EN
  always_ff @(negedge lclk_fdc_in) begin
    if (rst_fdc_in || !run_fdc_in) begin
      clock_half_fdc_negreg_out <= 1'b0;
    end else begin
      clock_half_fdc_negreg_out <= !clock_half_fdc_negreg_out;
    end
  end
`endif

endmodule
